// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: sizes, steers and aligns data accesses onto a
// valid/ready request + valid response bus, stalling the pipeline meanwhile.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_mem,
  input  logic        store_mem,
  input  logic [2:0]  func_3_mem,
  input  logic [31:0] alu_data_mem,
  input  logic [31:0] rs2_data_mem,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        access_error,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rdata
);

  // state    | meaning
  // IDLE     | waiting for a MEM-stage load/store; illegal ones flagged here
  // REQ      | request presented, waiting for bus_req_ready
  // WAIT_RSP | request accepted, waiting for response or timeout
  // DONE     | retiring cycle; MEM inputs deliberately not sampled
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  localparam logic [15:0] TMR_LOAD = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  func_3_q, func_3_d;
  logic [15:0] tmr_q, tmr_d;
  logic        timed_out_q, timed_out_d;
  logic [31:0] load_data_q, load_data_d;

  logic        access_req, f3_ok, size_ok, legal;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    f3_ok   = 1'b0;
    size_ok = 1'b0;
    case (func_3_mem)
      3'b000: begin f3_ok = 1'b1;     size_ok = 1'b1;                      end
      3'b001: begin f3_ok = 1'b1;     size_ok = ~alu_data_mem[0];          end
      3'b010: begin f3_ok = 1'b1;     size_ok = (alu_data_mem[1:0] == 2'b00); end
      3'b100: begin f3_ok = load_mem; size_ok = 1'b1;                      end
      3'b101: begin f3_ok = load_mem; size_ok = ~alu_data_mem[0];          end
      default: begin f3_ok = 1'b0;    size_ok = 1'b0;                      end
    endcase
  end

  assign access_req = load_mem | store_mem;
  assign legal      = access_req & f3_ok & size_ok;

  always_comb begin
    st_wdata = rs2_data_mem;
    st_wstrb = 4'b1111;
    case (func_3_mem[1:0])
      2'b00: begin
        st_wdata = {4{rs2_data_mem[7:0]}};
        st_wstrb = 4'b0001 << alu_data_mem[1:0];
      end
      2'b01: begin
        st_wdata = {2{rs2_data_mem[15:0]}};
        st_wstrb = 4'b0011 << {alu_data_mem[1], 1'b0};
      end
      default: begin
        st_wdata = rs2_data_mem;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // func_3_q[2] set means unsigned (BU/HU)
  always_comb begin
    ld_byte = 8'h00;
    case (addr_q[1:0])
      2'b00:   ld_byte = bus_rdata[7:0];
      2'b01:   ld_byte = bus_rdata[15:8];
      2'b10:   ld_byte = bus_rdata[23:16];
      default: ld_byte = bus_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (func_3_q[1:0])
      2'b00:   ld_ext = {{24{ld_byte[7] & ~func_3_q[2]}}, ld_byte};
      2'b01:   ld_ext = {{16{ld_half[15] & ~func_3_q[2]}}, ld_half};
      default: ld_ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    we_d          = we_q;
    wstrb_d       = wstrb_q;
    wdata_d       = wdata_q;
    func_3_d      = func_3_q;
    tmr_d         = tmr_q;
    timed_out_d   = timed_out_q;
    load_data_d   = load_data_q;
    stall         = 1'b0;
    load_valid    = 1'b0;
    access_error  = 1'b0;
    bus_req_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (legal) begin
          stall       = 1'b1;
          addr_d      = alu_data_mem;
          we_d        = store_mem;
          wstrb_d     = store_mem ? st_wstrb : 4'b0000;
          wdata_d     = store_mem ? st_wdata : 32'h0;
          func_3_d    = func_3_mem;
          timed_out_d = 1'b0;
          state_d     = REQ;
        end else if (access_req) begin
          access_error = 1'b1;
        end
      end
      REQ: begin
        stall         = 1'b1;
        bus_req_valid = 1'b1;
        if (bus_req_ready) begin
          tmr_d   = TMR_LOAD;
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        stall = 1'b1;
        if (bus_rsp_valid) begin
          if (!we_q) load_data_d = ld_ext;
          state_d = DONE;
        end else if (tmr_q == 16'd0) begin
          access_error = 1'b1;
          timed_out_d  = 1'b1;
          if (!we_q) load_data_d = 32'h0;
          state_d = DONE;
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
      end
      DONE: begin
        load_valid = ~we_q & ~timed_out_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= 32'h0;
      we_q        <= 1'b0;
      wstrb_q     <= 4'b0000;
      wdata_q     <= 32'h0;
      func_3_q    <= 3'b000;
      tmr_q       <= 16'h0;
      timed_out_q <= 1'b0;
      load_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      func_3_q    <= func_3_d;
      tmr_q       <= tmr_d;
      timed_out_q <= timed_out_d;
      load_data_q <= load_data_d;
    end
  end

  assign bus_addr  = {addr_q[31:2], 2'b00};
  assign bus_we    = we_q;
  assign bus_wstrb = wstrb_q;
  assign bus_wdata = wdata_q;
  assign load_data = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; expected values are hand-computed
// constants, outputs sampled 2 time units after each rising edge.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        load_mem, store_mem;
  logic [2:0]  func_3_mem;
  logic [31:0] alu_data_mem, rs2_data_mem;
  logic        stall, load_valid, access_error, bus_req_valid, bus_req_ready;
  logic [31:0] load_data, bus_addr, bus_wdata, bus_rdata;
  logic        bus_we, bus_rsp_valid;
  logic [3:0]  bus_wstrb;

  int total = 0;
  int bad   = 0;
  int cnt;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .load_mem(load_mem), .store_mem(store_mem),
    .func_3_mem(func_3_mem), .alu_data_mem(alu_data_mem), .rs2_data_mem(rs2_data_mem),
    .stall(stall), .load_data(load_data), .load_valid(load_valid),
    .access_error(access_error), .bus_req_valid(bus_req_valid),
    .bus_req_ready(bus_req_ready), .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rsp_valid(bus_rsp_valid),
    .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    load_mem = 1'b0; store_mem = 1'b0; func_3_mem = 3'b000;
    alu_data_mem = 32'h0; rs2_data_mem = 32'h0;
  endtask

  task automatic issue(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    load_mem = ld; store_mem = ~ld; func_3_mem = f3;
    alu_data_mem = a; rs2_data_mem = d;
    #1;
  endtask

  // best-case load: cycle0 IDLE, 1 REQ, 2 WAIT_RSP, 3 DONE
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rd, input logic [31:0] exp);
    bus_req_ready = 1'b1;
    issue(1'b1, f3, a, 32'h0);
    chk({tag, " c0 stall"}, 32'(stall), 32'd1);
    cyc(); idle_inputs();
    chk({tag, " req_valid"}, 32'(bus_req_valid), 32'd1);
    chk({tag, " addr"}, bus_addr, {a[31:2], 2'b00});
    chk({tag, " wstrb"}, 32'(bus_wstrb), 32'd0);
    chk({tag, " we"}, 32'(bus_we), 32'd0);
    cyc();
    bus_rsp_valid = 1'b1; bus_rdata = rd;
    chk({tag, " c2 stall"}, 32'(stall), 32'd1);
    chk({tag, " c2 req_valid"}, 32'(bus_req_valid), 32'd0);
    cyc();
    bus_rsp_valid = 1'b0; bus_rdata = 32'h0;
    chk({tag, " c3 stall"}, 32'(stall), 32'd0);
    chk({tag, " load_valid"}, 32'(load_valid), 32'd1);
    chk({tag, " load_data"}, load_data, exp);
    cyc();
    chk({tag, " lv after"}, 32'(load_valid), 32'd0);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] ea,
                          input logic [31:0] ewd, input logic [3:0] ews);
    bus_req_ready = 1'b1;
    issue(1'b0, f3, a, d);
    chk({tag, " c0 stall"}, 32'(stall), 32'd1);
    cyc(); idle_inputs();
    chk({tag, " req_valid"}, 32'(bus_req_valid), 32'd1);
    chk({tag, " addr"}, bus_addr, ea);
    chk({tag, " wdata"}, bus_wdata, ewd);
    chk({tag, " wstrb"}, 32'(bus_wstrb), 32'(ews));
    chk({tag, " we"}, 32'(bus_we), 32'd1);
    cyc();
    bus_rsp_valid = 1'b1;
    chk({tag, " c2 stall"}, 32'(stall), 32'd1);
    cyc();
    bus_rsp_valid = 1'b0;
    chk({tag, " c3 stall"}, 32'(stall), 32'd0);
    chk({tag, " c3 load_valid"}, 32'(load_valid), 32'd0);
    cyc();
  endtask

  task automatic do_illegal(input string tag, input logic ld, input logic [2:0] f3,
                            input logic [31:0] a);
    bus_req_ready = 1'b1;
    issue(ld, f3, a, 32'h5555AAAA);
    chk({tag, " err"}, 32'(access_error), 32'd1);
    chk({tag, " stall"}, 32'(stall), 32'd0);
    chk({tag, " req_valid"}, 32'(bus_req_valid), 32'd0);
    cyc(); idle_inputs(); #1;
    chk({tag, " err after"}, 32'(access_error), 32'd0);
    chk({tag, " req_valid after"}, 32'(bus_req_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = 32'h0;
    idle_inputs();
    cyc(); cyc();
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst load_data", load_data, 32'h0);
    chk("rst load_valid", 32'(load_valid), 32'd0);
    chk("rst err", 32'(access_error), 32'd0);
    chk("rst req_valid", 32'(bus_req_valid), 32'd0);
    chk("rst we", 32'(bus_we), 32'd0);
    chk("rst wstrb", 32'(bus_wstrb), 32'd0);
    chk("rst addr", bus_addr, 32'h0);
    chk("rst wdata", bus_wdata, 32'h0);
    rst = 1'b0;
    cyc();

    do_load("LW",  3'b010, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
    do_load("LB",  3'b000, 32'h103, 32'h80FF0011, 32'hFFFFFF80);
    do_load("LBU", 3'b100, 32'h103, 32'h80FF0011, 32'h00000080);
    do_load("LH",  3'b001, 32'h102, 32'h80FF0011, 32'hFFFF80FF);
    do_load("LHU", 3'b101, 32'h102, 32'h80FF0011, 32'h000080FF);
    do_load("LB0", 3'b000, 32'h104, 32'h80FF0011, 32'h00000011);
    do_load("LH0", 3'b001, 32'h104, 32'h1234F00D, 32'hFFFFF00D);

    do_store("SB", 3'b000, 32'h201, 32'h123456AB, 32'h200, 32'hABABABAB, 4'b0010);
    do_store("SH", 3'b001, 32'h202, 32'h123456AB, 32'h200, 32'h56AB56AB, 4'b1100);
    do_store("SW", 3'b010, 32'h300, 32'hCAFEF00D, 32'h300, 32'hCAFEF00D, 4'b1111);
    chk("load_data held", load_data, 32'hFFFFF00D);

    do_illegal("LW mis", 1'b1, 3'b010, 32'h102);
    do_illegal("SH mis", 1'b0, 3'b001, 32'h301);
    do_illegal("LD f3=011", 1'b1, 3'b011, 32'h100);
    do_illegal("ST f3=100", 1'b0, 3'b100, 32'h100);

    // ready withheld 4 REQ cycles, response on second WAIT_RSP cycle
    cnt = 0;
    bus_req_ready = 1'b0;
    issue(1'b1, 3'b010, 32'h400, 32'h0);
    if (stall) cnt++;
    cyc(); idle_inputs();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) bus_req_ready = 1'b1;
      #1;
      chk("slow req_valid", 32'(bus_req_valid), 32'd1);
      chk("slow addr", bus_addr, 32'h400);
      chk("slow wstrb", 32'(bus_wstrb), 32'd0);
      if (stall) cnt++;
      cyc();
    end
    bus_req_ready = 1'b0;
    if (stall) cnt++;
    cyc();
    bus_rsp_valid = 1'b1; bus_rdata = 32'h12345678;
    if (stall) cnt++;
    cyc();
    bus_rsp_valid = 1'b0;
    chk("slow stall cycles", 32'(cnt), 32'd8);
    chk("slow done stall", 32'(stall), 32'd0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (load_valid) cnt++;
      cyc();
    end
    chk("slow lv pulses", 32'(cnt), 32'd1);
    chk("slow load_data", load_data, 32'h12345678);

    // timeout with TIMEOUT_CYCLES=4
    bus_req_ready = 1'b1;
    issue(1'b1, 3'b010, 32'h500, 32'h0);
    cyc(); idle_inputs();
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("to early err", 32'(access_error), 32'd0);
      chk("to stall", 32'(stall), 32'd1);
      cyc();
    end
    chk("to err", 32'(access_error), 32'd1);
    cyc();
    chk("to done err", 32'(access_error), 32'd0);
    chk("to lv", 32'(load_valid), 32'd0);
    chk("to load_data", load_data, 32'h0);
    chk("to done stall", 32'(stall), 32'd0);
    cyc();
    chk("to idle req_valid", 32'(bus_req_valid), 32'd0);
    chk("to idle stall", 32'(stall), 32'd0);

    do_load("LW2", 3'b010, 32'h700, 32'hA5A5A5A5, 32'hA5A5A5A5);

    // reset during WAIT_RSP, then a late response
    issue(1'b1, 3'b010, 32'h600, 32'h0);
    cyc(); idle_inputs();
    cyc();
    chk("rw in wait", 32'(stall), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rw stall", 32'(stall), 32'd0);
    chk("rw load_data", load_data, 32'h0);
    chk("rw req_valid", 32'(bus_req_valid), 32'd0);
    chk("rw addr", bus_addr, 32'h0);
    chk("rw wstrb", 32'(bus_wstrb), 32'd0);
    bus_rsp_valid = 1'b1; bus_rdata = 32'h77777777;
    cyc();
    bus_rsp_valid = 1'b0;
    chk("rw late lv", 32'(load_valid), 32'd0);
    chk("rw late data", load_data, 32'h0);
    chk("rw late stall", 32'(stall), 32'd0);
    cyc();
    chk("rw late lv2", 32'(load_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
